// File: rtl/cla_seq_adder_ctrl_pkg.sv
// Shared types and defaults for the sequential CLA adder controller.
package cla_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cla_seq_state_t;

    localparam int CLA_SLICE_DEFAULT = 8;

endpackage

// File: rtl/cla_seq_adder_ctrl_if.sv
// Operand/result handshake bundle for cla_seq_adder_ctrl.
// The overflow signal exists only when CLA_SEQ_OVF_EN is defined.
interface cla_seq_adder_ctrl_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sub;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             busy;
`ifdef CLA_SEQ_OVF_EN
    logic             overflow;

    modport master (
        output in_valid, a, b, op_sub, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy, overflow
    );
    modport slave (
        input  in_valid, a, b, op_sub, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, busy, overflow
    );
`else
    modport master (
        output in_valid, a, b, op_sub, carry_in, out_ready,
        input  in_ready, out_valid, sum, carry_out, busy
    );
    modport slave (
        input  in_valid, a, b, op_sub, carry_in, out_ready,
        output in_ready, out_valid, sum, carry_out, busy
    );
`endif

endinterface

// File: rtl/cla_seq_adder_ctrl_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice (gate-level generate/propagate).
module cla_slice_add #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, fully flattened per bit
    for (genvar i = 0; i < SLICE; i++) begin : g_carry
        logic [i+1:0] terms;
        for (genvar j = 0; j <= i; j++) begin : g_term
            if (j == i) begin : g_last
                assign terms[j] = g[j];
            end else begin : g_chain
                assign terms[j] = g[j] & (&p[i:j+1]);
            end
        end
        assign terms[i+1] = cin & (&p[i:0]);
        assign c[i+1]     = |terms;
    end

    assign s    = p ^ c[SLICE-1:0];
    assign cout = c[SLICE];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Sequences one CLA slice over a WIDTH-bit add/sub, LS slice first, one slice per cycle.
// Optional signed-overflow output enabled by defining CLA_SEQ_OVF_EN.
module cla_seq_adder_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = CLA_SLICE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    cla_seq_adder_ctrl_if.slave  bus
);

    localparam int NS   = WIDTH / SLICE;
    localparam int IDXW = (NS > 1) ? $clog2(NS) : 1;

    if ((WIDTH % SLICE) != 0 || NS < 2) begin : g_param_chk
        $error("cla_seq_adder_ctrl: WIDTH (%0d) must be a multiple of SLICE (%0d) with at least 2 slices",
               WIDTH, SLICE);
    end

    cla_seq_state_t   state;
    cla_seq_state_t   state_nxt;
    logic [IDXW-1:0]  idx;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_cout;
    logic             accept;
    logic             last;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.sum       = sum_r;
    assign bus.carry_out = cout_r;

    assign accept = bus.in_valid && bus.in_ready;
    assign last   = (idx == IDXW'(NS - 1));
    assign sl_a   = a_r[idx*SLICE +: SLICE];
    assign sl_b   = b_r[idx*SLICE +: SLICE];

    cla_slice_add #(.SLICE(SLICE)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_r),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // B is stored post-inversion so RUN is the same datapath for add and sub
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_r     <= bus.a;
                    b_r     <= bus.op_sub ? ~bus.b : bus.b;
                    carry_r <= bus.op_sub ? 1'b1 : bus.carry_in;
                    idx     <= '0;
                end
                RUN: begin
                    sum_r[idx*SLICE +: SLICE] <= sl_s;
                    carry_r <= sl_cout;
                    idx     <= last ? '0 : idx + 1'b1;
                    if (last) cout_r <= sl_cout;
                end
                default: ;
            endcase
        end
    end

`ifdef CLA_SEQ_OVF_EN
    logic ovf_r;

    // Top slice result bit is the final sum MSB on the last RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_r <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sl_s[SLICE-1] != a_r[WIDTH-1]);
        end
    end

    assign bus.overflow = ovf_r;
`endif

endmodule
